l_output_port_ctrl: RTL
=======================

Name: l_output_port_ctrl

Overview:
Output-port controller for the local (L) output of the NOC router. It sits directly downstream of the L round-robin processor and consumes its one-hot priority grant and grant-valid (to-crossbar) strobe. It locks the L output to the winning input for a whole wormhole packet, from header to tail, and muxes that input's flits onto the L output under downstream credit flow control. On the tail it pulses rr_register_change_order_o back to the round-robin registers so the priority rotates.

Parameters:
FLIT_W, 32, flit width in bits (header/body/tail share the format)
CREDIT_DEPTH, 4, downstream L buffer depth; credit counter reset value (1..7)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rrp_l_priority_n_i / _s_i / _w_i / _e_i / _l_i  input  1 each  one-hot grant from L round-robin processor
rrp_l_priority_to_cs_i  input  1  grant valid strobe
n_flit_i / s_flit_i / w_flit_i / e_flit_i / l_flit_i  input  FLIT_W each  head flit of each input buffer
n_valid_i / s_valid_i / w_valid_i / e_valid_i / l_valid_i  input  1 each  input buffer non-empty
n_tail_i / s_tail_i / w_tail_i / e_tail_i / l_tail_i  input  1 each  head flit is tail (single-flit packet: header with tail=1)
credit_return_i  input  1  downstream freed one slot
n_pop_o / s_pop_o / w_pop_o / e_pop_o / l_pop_o  output  1 each  dequeue head flit of that input (combinational)
l_out_flit_o  output  FLIT_W  registered output flit
l_out_valid_o  output  1  registered output valid
rr_register_change_order_o  output  1  one-cycle rotate pulse to rr registers
l_busy_o  output  1  port locked to an owner
l_owner_o  output  3  encoded owner: n=0, s=1, w=2, e=3, l=4; 7 when idle
credit_cnt_o  output  3  current credit count
grant_err_o  output  1  one-cycle pulse on malformed grant

Behaviour:
- Two-state FSM: IDLE and LOCK.
- Reset values: state=IDLE, all pops 0, l_out_flit_o=0, l_out_valid_o=0, rr_register_change_order_o=0, l_busy_o=0, l_owner_o=7, credit_cnt_o=CREDIT_DEPTH, grant_err_o=0.
- IDLE -> LOCK: on a cycle with rrp_l_priority_to_cs_i=1 and exactly one priority bit set. Owner is latched at that clock edge. No flit moves in the grant cycle.
- Malformed grant (to_cs=1 with zero or more than one priority bit set): no lock; grant_err_o=1 on the next cycle; state stays IDLE.
- Priority inputs are ignored in LOCK and when to_cs=0.
- Transfer condition in LOCK: owner_valid & (credit_cnt>0).
  - owner's pop_o=1 combinationally in the same cycle; all other pops stay 0.
  - Next cycle: l_out_flit_o = owner flit, l_out_valid_o=1 (latency 1).
  - l_out_valid_o=0 in any cycle following a non-transfer cycle. l_out_flit_o holds its last value.
- LOCK -> IDLE: on a transfer with owner_tail=1.
  - The next cycle shows the tail on the output, rr_register_change_order_o=1 (exactly one cycle), l_busy_o=0, l_owner_o=7.
  - A new grant can be accepted in that same next cycle (IDLE).
- Back-to-back flits: with credits and valid continuously available, one flit per cycle.
- Credits:
  - Decrement on each transfer; increment on credit_return_i; both in the same cycle leaves the count unchanged.
  - Return while credit_cnt==CREDIT_DEPTH and no transfer: ignored (saturates).
  - credit_cnt==0 stalls transfer, pop=0, and the lock is kept.
- Owner valid low mid-packet: stall; the lock is held indefinitely (wormhole); no timeout.
- Reset mid-packet: lock dropped, credits restored to CREDIT_DEPTH, no rotate pulse, all outputs return to reset values on the next edge.
- Credit arithmetic: 3-bit unsigned, never wraps.

Test Plan:
- Reset, then to_cs=1 with w=1; 3-flit packet on w (tail on 3rd), credits 4 -> w_pop_o high for 3 consecutive cycles, outputs appear cycles +1..+3, credit_cnt 4->1, rotate pulse coincides with the tail output, l_owner_o 2->7.
- Single-flit packet on n (valid=1, tail=1) after grant -> one pop, one output flit, rotate pulse one cycle later, then IDLE.
- Credits exhausted: 6-flit packet with no returns -> 4 transfers, stall with pop=0 and l_busy_o=1. A credit_return_i pulse -> exactly one further transfer. Simultaneous transfer+return holds the count.
- Malformed grants: to_cs=1 with n=1,e=1, then to_cs=1 with all bits zero -> grant_err_o pulses each time, l_busy_o stays 0, no pops.
- Reset asserted mid-packet after 2 of 4 flits on s -> next cycle l_busy_o=0, credit_cnt=4, l_out_valid_o=0, no rotate pulse.
- Grant change during LOCK (owner e, priority switches to s with to_cs=1) -> ignored; only e_pop_o asserts until the e tail. Credit return at full count -> stays 4.

Source files
------------

// File: rtl/l_output_port_ctrl.sv
// Local (L) output-port controller for the NOC router.
// Locks the L output to the round-robin winner for a whole wormhole packet,
// forwards that input's flits under downstream credit flow control, and
// pulses a rotate request back to the round-robin registers on the tail.
//
// Handshake semantics (all interfaces):
//   <x>_valid_i  : input buffer <x> is non-empty; its head flit and tail flag
//                  are presented on <x>_flit_i / <x>_tail_i.
//   <x>_pop_o    : combinational dequeue; the head flit is consumed at the
//                  rising edge ending a cycle where valid and pop are both high.
//                  Pop is raised only for the locked owner, only while it is
//                  valid and at least one downstream credit is available.
//   l_out_valid_o: one flit is sent downstream per cycle it is high; the
//                  receiver returns each freed slot via credit_return_i.
module l_output_port_ctrl #(
  parameter int FLIT_W       = 32,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rrp_l_priority_n_i,
  input  logic              rrp_l_priority_s_i,
  input  logic              rrp_l_priority_w_i,
  input  logic              rrp_l_priority_e_i,
  input  logic              rrp_l_priority_l_i,
  input  logic              rrp_l_priority_to_cs_i,
  input  logic [FLIT_W-1:0] n_flit_i,
  input  logic [FLIT_W-1:0] s_flit_i,
  input  logic [FLIT_W-1:0] w_flit_i,
  input  logic [FLIT_W-1:0] e_flit_i,
  input  logic [FLIT_W-1:0] l_flit_i,
  input  logic              n_valid_i,
  input  logic              s_valid_i,
  input  logic              w_valid_i,
  input  logic              e_valid_i,
  input  logic              l_valid_i,
  input  logic              n_tail_i,
  input  logic              s_tail_i,
  input  logic              w_tail_i,
  input  logic              e_tail_i,
  input  logic              l_tail_i,
  input  logic              credit_return_i,
  output logic              n_pop_o,
  output logic              s_pop_o,
  output logic              w_pop_o,
  output logic              e_pop_o,
  output logic              l_pop_o,
  output logic [FLIT_W-1:0] l_out_flit_o,
  output logic              l_out_valid_o,
  output logic              rr_register_change_order_o,
  output logic              l_busy_o,
  output logic [2:0]        l_owner_o,
  output logic [2:0]        credit_cnt_o,
  output logic              grant_err_o,
  output logic              dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  localparam logic [2:0] OWNER_IDLE = 3'd7;
  localparam logic [2:0] CREDIT_MAX = 3'(CREDIT_DEPTH);

  state_t      state;
  logic [2:0]  owner_q;
  logic [2:0]  credit_q;
  logic [2:0]  credit_nxt;

  logic [4:0]  prio_vec;
  logic        grant_onehot;
  logic [2:0]  grant_idx;

  logic        owner_valid;
  logic        owner_tail;
  logic [FLIT_W-1:0] owner_flit;

  logic        xfer;
  logic [4:0]  pop_vec;

  // Input ordering everywhere: bit 0 = n, 1 = s, 2 = w, 3 = e, 4 = l.
  assign prio_vec = {rrp_l_priority_l_i, rrp_l_priority_e_i, rrp_l_priority_w_i,
                     rrp_l_priority_s_i, rrp_l_priority_n_i};

  // Decode the grant: only a strictly one-hot vector names a winner.
  always_comb begin
    grant_onehot = 1'b1;
    grant_idx    = OWNER_IDLE;
    case (prio_vec)
      5'b00001: grant_idx = 3'd0;
      5'b00010: grant_idx = 3'd1;
      5'b00100: grant_idx = 3'd2;
      5'b01000: grant_idx = 3'd3;
      5'b10000: grant_idx = 3'd4;
      default:  grant_onehot = 1'b0;
    endcase
  end

  // Select the head-of-line status and flit of the locked owner.
  always_comb begin
    owner_valid = 1'b0;
    owner_tail  = 1'b0;
    owner_flit  = '0;
    case (owner_q)
      3'd0: begin owner_valid = n_valid_i; owner_tail = n_tail_i; owner_flit = n_flit_i; end
      3'd1: begin owner_valid = s_valid_i; owner_tail = s_tail_i; owner_flit = s_flit_i; end
      3'd2: begin owner_valid = w_valid_i; owner_tail = w_tail_i; owner_flit = w_flit_i; end
      3'd3: begin owner_valid = e_valid_i; owner_tail = e_tail_i; owner_flit = e_flit_i; end
      3'd4: begin owner_valid = l_valid_i; owner_tail = l_tail_i; owner_flit = l_flit_i; end
      default: begin owner_valid = 1'b0; owner_tail = 1'b0; owner_flit = '0; end
    endcase
  end

  // A flit moves only while locked, owner has data and a downstream slot is
  // free. Reset blocks movement so no flit is dequeued and then discarded.
  assign xfer = !reset && (state == S_LOCK) && owner_valid && (credit_q != 3'd0);

  assign pop_vec = xfer ? (5'b00001 << owner_q) : 5'b00000;
  assign n_pop_o = pop_vec[0];
  assign s_pop_o = pop_vec[1];
  assign w_pop_o = pop_vec[2];
  assign e_pop_o = pop_vec[3];
  assign l_pop_o = pop_vec[4];

  // Credit update: transfer consumes, return refunds, both cancel; a return
  // at full count is dropped so the counter never exceeds the buffer depth.
  always_comb begin
    credit_nxt = credit_q;
    if (xfer && !credit_return_i) begin
      credit_nxt = credit_q - 3'd1;
    end else if (!xfer && credit_return_i && (credit_q < CREDIT_MAX)) begin
      credit_nxt = credit_q + 3'd1;
    end
  end

  // Lock FSM with all registered outputs: grant capture, flit forwarding,
  // tail release with rotate pulse, and malformed-grant flagging.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                      <= S_IDLE;
      owner_q                    <= OWNER_IDLE;
      credit_q                   <= CREDIT_MAX;
      l_out_flit_o               <= '0;
      l_out_valid_o              <= 1'b0;
      rr_register_change_order_o <= 1'b0;
      grant_err_o                <= 1'b0;
    end else begin
      l_out_valid_o              <= xfer;
      rr_register_change_order_o <= 1'b0;
      grant_err_o                <= 1'b0;
      credit_q                   <= credit_nxt;
      if (xfer) begin
        l_out_flit_o <= owner_flit;
      end
      case (state)
        S_IDLE: begin
          if (rrp_l_priority_to_cs_i) begin
            if (grant_onehot) begin
              state   <= S_LOCK;
              owner_q <= grant_idx;
            end else begin
              grant_err_o <= 1'b1;
            end
          end
        end
        S_LOCK: begin
          // Grant inputs are deliberately ignored here: the wormhole holds
          // until the owner's tail has been forwarded.
          if (xfer && owner_tail) begin
            state                      <= S_IDLE;
            owner_q                    <= OWNER_IDLE;
            rr_register_change_order_o <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          owner_q <= OWNER_IDLE;
        end
      endcase
    end
  end

  assign l_busy_o     = (state == S_LOCK);
  assign l_owner_o    = owner_q;
  assign credit_cnt_o = credit_q;
  assign dbg_state_o  = state;

endmodule
